// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline stall/flush control for load-use, taken branches and slow data memory.
module hazard_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_wbreg_i,
  input  logic        mem_branch_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        pipe_en_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        exmem_flush_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic        mem_err_o
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, BR_FLUSH = 2'd2} state_t;
  localparam logic [3:0] TO = 4'(TIMEOUT);
  state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_inc;
  logic load_use, mem_wait;
  assign load_use = ex_memread_i & (ex_wbreg_i != 5'd0) &
                    ((ex_wbreg_i == id_rs_i) | (ex_wbreg_i == id_rt_i));
  assign mem_wait = dmem_req_i & ~dmem_ready_i;
  assign wait_inc = (wait_cnt == 4'hF) ? 4'hF : wait_cnt + 4'd1;
  assign state_o  = state;
  always_comb begin
    state_nxt     = state;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    pipe_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    case (state)
      RUN:
        if (mem_wait) begin
          {pc_write_o, ifid_write_o, pipe_en_o} = 3'b000;
          state_nxt = MEM_WAIT;
        end else if (mem_branch_i) begin
          {ifid_flush_o, idex_flush_o, exmem_flush_o} = 3'b111;
          state_nxt = BR_FLUSH;
        end else if (load_use) begin
          {pc_write_o, ifid_write_o, idex_flush_o} = 3'b001;
        end
      MEM_WAIT:
        if (!dmem_ready_i) {pc_write_o, ifid_write_o, pipe_en_o} = 3'b000;
        else state_nxt = RUN;
      BR_FLUSH:
        if (mem_wait) begin
          {pc_write_o, ifid_write_o, pipe_en_o} = 3'b000;
          state_nxt = MEM_WAIT;
        end else begin
          ifid_flush_o = 1'b1;
          state_nxt = RUN;
        end
      default: state_nxt = RUN;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= RUN;
      wait_cnt    <= 4'd0;
      stall_cnt_o <= 16'd0;
      mem_err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!pc_write_o && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
      if (state != MEM_WAIT && state_nxt == MEM_WAIT) wait_cnt <= 4'd0;
      else if (state == MEM_WAIT) wait_cnt <= wait_inc;
      if (state == MEM_WAIT && wait_inc == TO) mem_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: vector table plus multi-cycle sequences, scored through an expected-output queue.
module tb_hazard_sequencer;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic [4:0] id_rs_i, id_rt_i, ex_wbreg_i;
  logic ex_memread_i, mem_branch_i, dmem_req_i, dmem_ready_i;
  logic pc_write_o, ifid_write_o, pipe_en_o, ifid_flush_o, idex_flush_o, exmem_flush_o, mem_err_o;
  logic [1:0] state_o;
  logic [15:0] stall_cnt_o;

  hazard_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .ex_memread_i(ex_memread_i), .ex_wbreg_i(ex_wbreg_i), .mem_branch_i(mem_branch_i),
    .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o), .pipe_en_o(pipe_en_o), .ifid_flush_o(ifid_flush_o),
    .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  // expected packing: {pc_write, ifid_write, pipe_en, ifid_flush, idex_flush, exmem_flush, state[1:0]}
  typedef struct {
    string      name;
    logic [4:0] rs, rt, wb;
    logic       mr, br, rq, rd;
    logic [7:0] ex;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] sb[$];
  int tests = 0, fails = 0;
  logic [15:0] model_stall = 16'd0;

  function automatic vec_t mk(input string n, input logic [4:0] rs, rt, wb,
                              input logic mr, br, rq, rd, input logic [7:0] ex);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.wb = wb;
    v.mr = mr; v.br = br; v.rq = rq; v.rd = rd; v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {pc_write_o, ifid_write_o, pipe_en_o, ifid_flush_o, idex_flush_o, exmem_flush_o, state_o};
  endfunction

  task automatic step(input vec_t v);
    logic [7:0] e;
    id_rs_i = v.rs; id_rt_i = v.rt; ex_wbreg_i = v.wb; ex_memread_i = v.mr;
    mem_branch_i = v.br; dmem_req_i = v.rq; dmem_ready_i = v.rd;
    sb.push_back(v.ex);
    @(negedge clk_i);
    e = sb.pop_front();
    chk(v.name, {8'd0, outs()}, {8'd0, e});
    chk({v.name, "/stall_cnt"}, stall_cnt_o, model_stall);
    if (!e[7] && model_stall != 16'hFFFF) model_stall++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(mk("idle", 0, 0, 0, 0, 0, 0, 0, 8'hE0));
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    model_stall = 16'd0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  initial begin
    {id_rs_i, id_rt_i, ex_wbreg_i} = '0;
    {ex_memread_i, mem_branch_i, dmem_req_i, dmem_ready_i} = '0;
    #3;
    chk("reset/outs", {8'd0, outs()}, 16'h00E0);
    chk("reset/stall_cnt", stall_cnt_o, 16'd0);
    chk("reset/mem_err", {15'd0, mem_err_o}, 16'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    tbl.push_back(mk("run_idle",        0, 0, 0, 0, 0, 0, 0, 8'hE0));
    tbl.push_back(mk("load_use_rs",     5, 0, 5, 1, 0, 0, 0, 8'h28));
    tbl.push_back(mk("after_load_use",  0, 0, 0, 0, 0, 0, 0, 8'hE0));
    tbl.push_back(mk("load_use_rt",     3, 7, 7, 1, 0, 0, 0, 8'h28));
    tbl.push_back(mk("wb_zero_no_stall",0, 0, 0, 1, 0, 0, 0, 8'hE0));
    tbl.push_back(mk("no_memread",      5, 5, 5, 0, 0, 0, 0, 8'hE0));
    tbl.push_back(mk("wb_mismatch",     6, 7, 5, 1, 0, 0, 0, 8'hE0));
    tbl.push_back(mk("dmem_ready_lu",   9, 0, 9, 1, 0, 1, 1, 8'h28));
    tbl.push_back(mk("dmem_ready_only", 0, 0, 0, 0, 0, 1, 1, 8'hE0));
    foreach (tbl[i]) step(tbl[i]);

    // three-cycle memory wait, then completion
    step(mk("mw_enter", 0, 0, 0, 0, 0, 1, 0, 8'h00));
    step(mk("mw_hold1", 0, 0, 0, 0, 0, 1, 0, 8'h01));
    step(mk("mw_hold2", 0, 0, 0, 0, 0, 1, 0, 8'h01));
    step(mk("mw_done",  0, 0, 0, 0, 0, 1, 1, 8'hE1));
    idle();

    // branch coinciding with load-use wins, then one ifid flush cycle ignoring load-use
    step(mk("br_lu",       5, 0, 5, 1, 1, 0, 0, 8'hFC));
    step(mk("br_flush_lu", 5, 0, 5, 1, 0, 0, 0, 8'hF2));
    idle();

    // memory wait arriving during BR_FLUSH takes precedence
    step(mk("br2",          0, 0, 0, 0, 1, 0, 0, 8'hFC));
    step(mk("br_flush_mw",  0, 0, 0, 0, 0, 1, 0, 8'h02));
    step(mk("br_mw_hold",   0, 0, 0, 0, 0, 1, 0, 8'h01));
    step(mk("br_mw_done",   0, 0, 0, 0, 0, 1, 1, 8'hE1));
    idle();

    // timeout: ready low for 16 cycles
    chk("mem_err_before", {15'd0, mem_err_o}, 16'd0);
    step(mk("to_enter", 0, 0, 0, 0, 0, 1, 0, 8'h00));
    for (int i = 0; i < 15; i++) step(mk("to_hold", 0, 0, 0, 0, 0, 1, 0, 8'h01));
    chk("mem_err_set", {15'd0, mem_err_o}, 16'd1);
    step(mk("to_done", 0, 0, 0, 0, 0, 1, 1, 8'hE1));
    idle();
    chk("mem_err_sticky", {15'd0, mem_err_o}, 16'd1);

    // asynchronous reset in the middle of MEM_WAIT
    step(mk("ar_enter", 0, 0, 0, 0, 0, 1, 0, 8'h00));
    step(mk("ar_hold",  0, 0, 0, 0, 0, 1, 0, 8'h01));
    #2 rst_i = 1'b0;
    #1;
    chk("async_rst/state", {14'd0, state_o}, 16'd0);
    chk("async_rst/stall_cnt", stall_cnt_o, 16'd0);
    chk("async_rst/mem_err", {15'd0, mem_err_o}, 16'd0);
    {dmem_req_i, dmem_ready_i} = 2'b00;
    #1 chk("async_rst/outs", {8'd0, outs()}, 16'h00E0);
    do_reset();
    idle();

    // reset in the middle of BR_FLUSH leaves no residual flush
    step(mk("rb_branch", 0, 0, 0, 0, 1, 0, 0, 8'hFC));
    do_reset();
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
